if_pc_ctrl: RTL and testbench

IF_PC_CTRL -- requirements
Module: if_pc_ctrl

---
 rtl/if_pc_ctrl_pkg.sv | 15 +
 rtl/if_pc_ctrl_jump_target_calc.sv | 13 +
 rtl/if_pc_ctrl.sv | 114 +++++++++++
 tb/tb_if_pc_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_pc_ctrl_pkg.sv
// Shared pipeline definitions for the instruction-fetch PC controller:
// FSM state encodings, reset vector default and instruction field widths.
package if_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pcState_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int JUMP_INDEX_W = 26;
  localparam int PC_REGION_W  = 4;

endpackage

// File: rtl/if_pc_ctrl_jump_target_calc.sv
// Pure combinational J/JAL target formation: the 4-bit region of the
// sequential PC, the 26-bit word index, and a word-aligned zero tail.
module jump_target_calc
  import if_pc_ctrl_pkg::*;
(
  input  logic [PC_REGION_W-1:0]  pcRegion,
  input  logic [JUMP_INDEX_W-1:0] jumpIndex,
  output logic [31:0]             jumpTarget
);

  assign jumpTarget = {pcRegion, jumpIndex, 2'b00};

endmodule

// File: rtl/if_pc_ctrl.sv
// Fetch PC controller: sequential fetch, branch/jump redirects with flushes,
// and a pending-redirect state that waits for instruction memory to accept.
module if_pc_ctrl
  import if_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          CNT_W        = 16
) (
  input  logic                    inClk,
  input  logic                    inResetN,
  input  logic                    inStall,
  input  logic                    inImemReady,
  input  logic                    inJump,
  input  logic [JUMP_INDEX_W-1:0] inJumpIndex,
  input  logic                    inBranchTaken,
  input  logic [31:0]             inBranchTarget,
  output logic [31:0]             outPc,
  output logic [31:0]             outPostPc,
  output logic                    outFetchValid,
  output logic                    outFlushIF,
  output logic                    outFlushID,
  output logic [1:0]              outState,
  output logic [CNT_W-1:0]        outRedirectCount
);

  pcState_t          state, stateNext;
  logic [31:0]       pc, pcNext;
  logic [31:0]       pendTarget, pendNext;
  logic [CNT_W-1:0]  redirectCount, countNext;
  logic              countInc;
  logic [31:0]       postPc;
  logic [31:0]       jumpTarget;
  logic [31:0]       branchTarget;
  logic              redirect;
  logic [31:0]       redirectTarget;

  assign postPc       = pc + 32'd4;
  assign branchTarget = inBranchTarget & 32'hFFFF_FFFC;

  jump_target_calc uJumpTarget (
    .pcRegion   (postPc[31:32-PC_REGION_W]),
    .jumpIndex  (inJumpIndex),
    .jumpTarget (jumpTarget)
  );

  // Branch in EX is older than the jump in ID, so it always wins.
  assign redirect       = inBranchTaken | inJump;
  assign redirectTarget = inBranchTaken ? branchTarget : jumpTarget;

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      pendTarget    <= 32'h0000_0000;
      redirectCount <= '0;
    end else begin
      state         <= stateNext;
      pc            <= pcNext;
      pendTarget    <= pendNext;
      redirectCount <= countNext;
    end
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    pendNext   = pendTarget;
    countNext  = redirectCount;
    countInc   = 1'b0;
    outFlushIF = 1'b0;
    outFlushID = 1'b0;
    case (state)
      BOOT: stateNext = RUN;
      RUN: begin
        outFlushIF = redirect;
        outFlushID = inBranchTaken;
        if (inImemReady) begin
          if (redirect) begin
            pcNext   = redirectTarget;
            countInc = 1'b1;
          end else if (!inStall) begin
            pcNext = postPc;
          end
        end else if (redirect) begin
          pendNext  = redirectTarget;
          countInc  = 1'b1;
          stateNext = PEND;
        end
      end
      // A jump seen here sits on the wrong path behind the pending redirect.
      PEND: begin
        outFlushIF = inBranchTaken;
        outFlushID = inBranchTaken;
        if (inImemReady) begin
          pcNext    = inBranchTaken ? branchTarget : pendTarget;
          stateNext = RUN;
        end else if (inBranchTaken) begin
          pendNext = branchTarget;
        end
      end
      default: stateNext = BOOT;
    endcase
    if (countInc && (redirectCount != '1)) begin
      countNext = redirectCount + CNT_W'(1);
    end
  end

  assign outPc            = pc;
  assign outPostPc        = postPc;
  assign outFetchValid    = (state == RUN);
  assign outState         = state;
  assign outRedirectCount = redirectCount;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed bench for if_pc_ctrl: boot sequence, jump/branch redirects,
// pending redirects under memory backpressure, wraparound, stall and reset.
module tb_if_pc_ctrl;

  logic        inClk;
  logic        inResetN;
  logic        inStall;
  logic        inImemReady;
  logic        inJump;
  logic [25:0] inJumpIndex;
  logic        inBranchTaken;
  logic [31:0] inBranchTarget;
  logic [31:0] outPc;
  logic [31:0] outPostPc;
  logic        outFetchValid;
  logic        outFlushIF;
  logic        outFlushID;
  logic [1:0]  outState;
  logic [15:0] outRedirectCount;

  int checkCount = 0;
  int errorCount = 0;

  if_pc_ctrl #(.RESET_VECTOR(32'h0000_0000), .CNT_W(16)) dut (
    .inClk            (inClk),
    .inResetN         (inResetN),
    .inStall          (inStall),
    .inImemReady      (inImemReady),
    .inJump           (inJump),
    .inJumpIndex      (inJumpIndex),
    .inBranchTaken    (inBranchTaken),
    .inBranchTarget   (inBranchTarget),
    .outPc            (outPc),
    .outPostPc        (outPostPc),
    .outFetchValid    (outFetchValid),
    .outFlushIF       (outFlushIF),
    .outFlushID       (outFlushID),
    .outState         (outState),
    .outRedirectCount (outRedirectCount)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic ready,
                               input logic jump, input logic [25:0] idx,
                               input logic br, input logic [31:0] tgt);
    inStall        = stall;
    inImemReady    = ready;
    inJump         = jump;
    inJumpIndex    = idx;
    inBranchTaken  = br;
    inBranchTarget = tgt;
    #1;
  endtask

  // Advance one clock and settle away from the active edge.
  task automatic tick();
    @(posedge inClk);
    #2;
  endtask

  initial begin
    inResetN = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
    @(posedge inClk);
    #2;
    checkOutput("rstPc", outPc, 32'h0);
    checkOutput("rstState", 32'(outState), 32'd0);
    checkOutput("rstValid", 32'(outFetchValid), 32'd0);
    checkOutput("rstFlushIF", 32'(outFlushIF), 32'd0);
    checkOutput("rstCount", 32'(outRedirectCount), 32'd0);

    // Boot sequence: pc 0,0,4,8 and fetchValid 0,1,1,1
    inResetN = 1'b1;
    #1;
    checkOutput("bootPc0", outPc, 32'h0);
    checkOutput("bootValid0", 32'(outFetchValid), 32'd0);
    checkOutput("bootFlushID", 32'(outFlushID), 32'd0);
    tick();
    checkOutput("bootPc1", outPc, 32'h0);
    checkOutput("bootValid1", 32'(outFetchValid), 32'd1);
    checkOutput("bootState1", 32'(outState), 32'd1);
    tick();
    checkOutput("bootPc2", outPc, 32'h4);
    checkOutput("postPc2", outPostPc, 32'h8);
    tick();
    checkOutput("bootPc3", outPc, 32'h8);
    checkOutput("bootValid3", 32'(outFetchValid), 32'd1);

    // Branch into region 4, then a jump from 0x40000010
    applyStimulus(1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'h4000_0010);
    checkOutput("brFlushIF", 32'(outFlushIF), 32'd1);
    checkOutput("brFlushID", 32'(outFlushID), 32'd1);
    tick();
    checkOutput("brPc", outPc, 32'h4000_0010);
    checkOutput("brCount", 32'(outRedirectCount), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 26'h000_0040, 1'b0, 32'h0);
    checkOutput("jmpFlushIF", 32'(outFlushIF), 32'd1);
    checkOutput("jmpFlushID", 32'(outFlushID), 32'd0);
    tick();
    checkOutput("jmpPc", outPc, 32'h4000_0100);
    checkOutput("jmpCount", 32'(outRedirectCount), 32'd2);

    // Branch and jump together: branch wins, low bits cleared
    applyStimulus(1'b0, 1'b1, 1'b1, 26'h123_4567, 1'b1, 32'h0000_0203);
    checkOutput("bothFlushIF", 32'(outFlushIF), 32'd1);
    checkOutput("bothFlushID", 32'(outFlushID), 32'd1);
    tick();
    checkOutput("bothPc", outPc, 32'h0000_0200);
    checkOutput("bothCount", 32'(outRedirectCount), 32'd3);

    // Memory not ready: branch 0x80 captured, newer branch 0xC0 overwrites,
    // a jump while pending is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h0000_0080);
    checkOutput("pendFlushIF", 32'(outFlushIF), 32'd1);
    tick();
    checkOutput("pendState", 32'(outState), 32'd2);
    checkOutput("pendPcHold", outPc, 32'h0000_0200);
    checkOutput("pendValid", 32'(outFetchValid), 32'd0);
    checkOutput("pendCount", 32'(outRedirectCount), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h0000_00C0);
    tick();
    checkOutput("pendOvrPc", outPc, 32'h0000_0200);
    checkOutput("pendOvrCount", 32'(outRedirectCount), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 26'h000_0400, 1'b0, 32'h0);
    checkOutput("pendJmpFlushIF", 32'(outFlushIF), 32'd0);
    tick();
    checkOutput("pendJmpState", 32'(outState), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
    tick();
    checkOutput("pendDonePc", outPc, 32'h0000_00C0);
    checkOutput("pendDoneState", 32'(outState), 32'd1);
    checkOutput("pendDoneCount", 32'(outRedirectCount), 32'd4);

    // Wraparound from the top of the address space
    applyStimulus(1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrapPc", outPc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("wrapPostPc", outPostPc, 32'h0);
    tick();
    checkOutput("wrapPcNext", outPc, 32'h0);

    // Stall holds the PC; a redirect overrides the stall
    applyStimulus(1'b1, 1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("stallPc", outPc, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 26'h0, 1'b1, 32'h0000_0010);
    tick();
    checkOutput("stallBrPc", outPc, 32'h0000_0010);
    checkOutput("stallBrCount", 32'(outRedirectCount), 32'd6);

    // Reset in the middle of a pending redirect discards it
    applyStimulus(1'b0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h0000_0300);
    tick();
    checkOutput("rst2PendState", 32'(outState), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 26'h0, 1'b0, 32'h0);
    inResetN = 1'b0;
    #1;
    checkOutput("rst2Pc", outPc, 32'h0);
    checkOutput("rst2State", 32'(outState), 32'd0);
    checkOutput("rst2Count", 32'(outRedirectCount), 32'd0);
    tick();
    inResetN = 1'b1;
    #1;
    tick();
    checkOutput("rst2RunPc", outPc, 32'h0);
    checkOutput("rst2RunState", 32'(outState), 32'd1);
    tick();
    checkOutput("rst2SeqPc", outPc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
